// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Access-size and FSM encodings, plus lane-count/offset-width helpers keyed on XLEN.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int unsigned RD_W = 5;

   function automatic int unsigned lane_count(int unsigned xlen);
      return xlen / 8;
   endfunction

   function automatic int unsigned off_width(int unsigned xlen);
      return $clog2(xlen / 8);
   endfunction

   // Number of bytes touched by an access of the given size code.
   function automatic logic [3:0] size_bytes(logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store shift/byte enables and load shift/extend.
// LSU_MISALIGN_TRAP_EN: flag misaligned addresses instead of forcing natural alignment.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32,
   localparam int unsigned LANES = lane_count(XLEN),
   localparam int unsigned OFF_W = off_width(XLEN)
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        size,
   input  logic [XLEN-1:0]   wdata,
   input  logic [OFF_W-1:0]  ld_off,
   input  logic [1:0]        ld_size,
   input  logic              ld_unsigned,
   input  logic [XLEN-1:0]   rdata,
   output logic [ADDR_W-1:0] addr_c,
   output logic [OFF_W-1:0]  off_c,
   output logic [LANES-1:0]  be_c,
   output logic [XLEN-1:0]   wdata_c,
   output logic              misalign_c,
   output logic              bad_size_c,
   output logic [XLEN-1:0]   load_c
);

   logic [OFF_W-1:0] lo;
   logic [OFF_W-1:0] align_mask;
   logic [6:0]       st_bits;
   logic [6:0]       ld_bits;
   logic [XLEN-1:0]  st_mask;
   logic [XLEN-1:0]  ld_mask;
   logic [XLEN-1:0]  ld_shift;
   logic             ld_sign;

   always_comb begin
      lo         = addr[OFF_W-1:0];
      align_mask = OFF_W'(size_bytes(size) - 4'd1);
      bad_size_c = (XLEN == 32) && (size_t'(size) == SZ_DWORD);
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_c = |(lo & align_mask);
`else
      misalign_c = 1'b0;
`endif
      off_c  = lo & ~align_mask;
      addr_c = {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      be_c   = LANES'((9'd1 << size_bytes(size)) - 9'd1) << off_c;

      // Shifting an all-ones word by >= XLEN yields zero, so full-width sizes mask to all ones.
      st_bits = 7'(size_bytes(size)) << 3;
      st_mask = ~({XLEN{1'b1}} << st_bits);
      wdata_c = (wdata & st_mask) << {off_c, 3'b000};

      ld_shift = rdata >> {ld_off, 3'b000};
      ld_bits  = 7'(size_bytes(ld_size)) << 3;
      ld_mask  = ~({XLEN{1'b1}} << ld_bits);
      ld_sign  = |(ld_shift & ld_mask & ~(ld_mask >> 1));
      load_c   = (ld_shift & ld_mask) | ((ld_sign && !ld_unsigned) ? ~ld_mask : '0);
   end

endmodule

// File: rtl/lsu_mem_unit.sv
// MEM-stage load/store unit: valid/ready bus master with sized accesses and bus timeout.
// LSU_MISALIGN_TRAP_EN: misaligned accesses complete with an error and never reach the bus.
module lsu_mem_unit
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [4:0]        req_rd,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_be,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              resp_valid,
   output logic [4:0]        resp_rd,
   output logic [XLEN-1:0]   resp_data,
   output logic              resp_err,
   output logic              stall
);

   localparam int unsigned LANES     = lane_count(XLEN);
   localparam int unsigned OFF_W     = off_width(XLEN);
   localparam int unsigned CNT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam int unsigned WAIT_LAST = (MAX_WAIT == 0) ? 0 : MAX_WAIT - 1;

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [OFF_W-1:0]  ld_off, ld_off_next;
   logic [1:0]        ld_size, ld_size_next;
   logic              ld_unsigned, ld_unsigned_next;
   logic [RD_W-1:0]   rd_q, rd_next;
   logic              write_next;
   logic [ADDR_W-1:0] addr_next;
   logic [XLEN-1:0]   wdata_next;
   logic [LANES-1:0]  be_next;
   logic [RD_W-1:0]   rsp_rd_next;
   logic [XLEN-1:0]   rsp_data_next;
   logic              rsp_err_next;

   logic [ADDR_W-1:0] addr_c;
   logic [OFF_W-1:0]  off_c;
   logic [LANES-1:0]  be_c;
   logic [XLEN-1:0]   wdata_c;
   logic              misalign_c;
   logic              bad_size_c;
   logic [XLEN-1:0]   load_c;

   lsu_align #(
      .XLEN   (XLEN),
      .ADDR_W (ADDR_W)
   ) u_align (
      .addr        (req_addr),
      .size        (req_size),
      .wdata       (req_wdata),
      .ld_off      (ld_off),
      .ld_size     (ld_size),
      .ld_unsigned (ld_unsigned),
      .rdata       (mem_rdata),
      .addr_c      (addr_c),
      .off_c       (off_c),
      .be_c        (be_c),
      .wdata_c     (wdata_c),
      .misalign_c  (misalign_c),
      .bad_size_c  (bad_size_c),
      .load_c      (load_c)
   );

   // Next-state, request latch and response computation.
   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      ld_off_next      = ld_off;
      ld_size_next     = ld_size;
      ld_unsigned_next = ld_unsigned;
      rd_next          = rd_q;
      write_next       = mem_write;
      addr_next        = mem_addr;
      wdata_next       = mem_wdata;
      be_next          = mem_be;
      rsp_rd_next      = '0;
      rsp_data_next    = '0;
      rsp_err_next     = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (req_valid) begin
               rd_next = req_write ? '0 : req_rd;
               if (misalign_c || bad_size_c) begin
                  state_next   = ST_RESP;
                  rsp_err_next = 1'b1;
                  rsp_rd_next  = rd_next;
               end else begin
                  state_next       = ST_BUS;
                  cnt_next         = '0;
                  ld_off_next      = off_c;
                  ld_size_next     = req_size;
                  ld_unsigned_next = req_unsigned;
                  write_next       = req_write;
                  addr_next        = addr_c;
                  wdata_next       = wdata_c;
                  be_next          = be_c;
               end
            end
         end
         ST_BUS: begin
            // A completing handshake beats a timeout landing in the same cycle.
            if (mem_ready) begin
               state_next    = ST_RESP;
               rsp_rd_next   = rd_q;
               rsp_data_next = mem_write ? '0 : load_c;
            end else if (MAX_WAIT != 0 && cnt == CNT_W'(WAIT_LAST)) begin
               state_next   = ST_RESP;
               rsp_rd_next  = rd_q;
               rsp_err_next = 1'b1;
            end else if (MAX_WAIT != 0) begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // State, latches and registered outputs.
   always_ff @(posedge clk) begin
      if (clr) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         ld_off      <= '0;
         ld_size     <= '0;
         ld_unsigned <= 1'b0;
         rd_q        <= '0;
         req_ready   <= 1'b1;
         mem_valid   <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
         resp_valid  <= 1'b0;
         resp_rd     <= '0;
         resp_data   <= '0;
         resp_err    <= 1'b0;
         stall       <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         ld_off      <= ld_off_next;
         ld_size     <= ld_size_next;
         ld_unsigned <= ld_unsigned_next;
         rd_q        <= rd_next;
         req_ready   <= (state_next == ST_IDLE);
         mem_valid   <= (state_next == ST_BUS);
         mem_write   <= write_next;
         mem_addr    <= addr_next;
         mem_wdata   <= wdata_next;
         mem_be      <= be_next;
         resp_valid  <= (state_next == ST_RESP);
         resp_rd     <= rsp_rd_next;
         resp_data   <= rsp_data_next;
         resp_err    <= rsp_err_next;
         stall       <= (state_next != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Scoreboard bench for lsu_mem_unit (XLEN=32): random and directed accesses checked
// against an arithmetic reference model of sizing, alignment, extension and timeout.
module tb_lsu_mem_unit;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned MAX_WAIT = 6;
   localparam int          NEVER    = 1000;

   logic        clk = 1'b0;
   logic        clr;
   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_valid, mem_ready, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        resp_valid, resp_err, stall;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data;

   lsu_mem_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_data(resp_data),
      .resp_err(resp_err), .stall(stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [4:0] rd; logic err; logic [31:0] data; int at; } rsp_t;
   typedef struct { logic [68:0] beat; int last; } bus_t;
   typedef struct { int first; int last; int ready_at; logic [31:0] rdata; } plan_t;

   rsp_t  rsp_q[$];
   bus_t  bus_q[$];
   plan_t plan_q[$];

   int tests = 0;
   int fails = 0;
   bit en    = 1'b0;

   // Expected activity window of the transaction in flight, in cycle numbers.
   int busy_lo = 1, busy_hi = 0, mv_hi = 0, rsp_at = -1;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: what one request should do on the bus and in its response.
   function automatic void model(input logic wr, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int d,
                                 output bit nobus, output bit err, output logic [31:0] data,
                                 output logic [68:0] beat, output int bc);
      longint nb, a, lane, lim, v;
      nobus = 1'b0; err = 1'b0; data = '0; beat = '0; bc = 0;
      nb = longint'(1) << sz;
      if (sz == 2'd3) begin nobus = 1'b1; err = 1'b1; return; end
`ifdef LSU_MISALIGN_TRAP_EN
      if (longint'({32'h0, addr}) % nb != 0) begin nobus = 1'b1; err = 1'b1; return; end
`endif
      a    = longint'({32'h0, addr});
      a    = a - (a % nb);
      lane = a % 4;
      lim  = longint'(1) << (8 * nb);
      beat = {wr, 32'(a - lane), 4'(((longint'(1) << nb) - 1) << lane),
              32'((longint'({32'h0, wd}) % lim) << (8 * lane))};
      bc = (d >= int'(MAX_WAIT)) ? int'(MAX_WAIT) : d + 1;
      if (d >= int'(MAX_WAIT)) begin err = 1'b1; return; end
      if (!wr) begin
         v = (longint'({32'h0, rdata}) >> (8 * lane)) % lim;
         if (!uns && v >= lim / 2) v = v - lim;
         data = 32'(v);
      end
   endfunction

   task automatic junk_req();
      req_write    = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      req_rd       = 5'($urandom);
   endtask

   // Issue one request at the current negedge; optionally ride it out to IDLE.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input int d, input logic [31:0] rdata, input bit wait_done);
      bit nobus, err;
      logic [31:0] data;
      logic [68:0] beat;
      int bc, c;
      rsp_t r;
      c = cyc;
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd; req_rd = rd;
      model(wr, sz, uns, addr, wd, rdata, d, nobus, err, data, beat, bc);
      busy_lo = c + 1;
      if (nobus) begin
         mv_hi = c; busy_hi = c + 1; rsp_at = c + 1;
      end else begin
         mv_hi = c + bc; busy_hi = c + 1 + bc; rsp_at = c + 1 + bc;
         bus_q.push_back('{beat: beat, last: c + bc});
         plan_q.push_back('{first: c + 1, last: c + bc,
                            ready_at: (err ? -1 : c + 1 + d), rdata: rdata});
      end
      r.rd = wr ? 5'd0 : rd; r.err = err; r.data = data; r.at = rsp_at;
      rsp_q.push_back(r);
      if (wait_done) begin
         do begin
            @(negedge clk);
            if (cyc <= rsp_at) begin
               req_valid = 1'($urandom);
               junk_req();
            end else begin
               req_valid = 1'b0;
            end
         end while (cyc <= rsp_at);
      end
   endtask

   // Bus responder: ready on the planned cycle, random noise outside bus windows.
   always @(negedge clk) begin
      if (plan_q.size() != 0 && cyc >= plan_q[0].first && cyc <= plan_q[0].last) begin
         if (cyc == plan_q[0].ready_at) begin
            mem_ready = 1'b1;
            mem_rdata = plan_q[0].rdata;
         end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
         end
         if (cyc == plan_q[0].last) void'(plan_q.pop_front());
      end else begin
         mem_ready = 1'($urandom);
         mem_rdata = $urandom;
      end
   end

   // Control-timing monitor.
   always @(negedge clk) begin
      bit busy, mv, rv;
      if (en) begin
         busy = (cyc >= busy_lo) && (cyc <= busy_hi);
         mv   = (cyc >= busy_lo) && (cyc <= mv_hi);
         rv   = (cyc == rsp_at);
         check("ctrl{ready,stall,mvalid,rvalid}", {req_ready, stall, mem_valid, resp_valid},
               {!busy, busy, mv, rv});
      end
   end

   // Bus-beat monitor: payload must match and hold every cycle mem_valid is up.
   always @(negedge clk) begin
      if (en && mem_valid) begin
         if (bus_q.size() == 0) begin
            check("bus_unexpected", mem_valid, 1'b0);
         end else begin
            check("bus_beat{wr,addr,be,wdata}", {mem_write, mem_addr, mem_be, mem_wdata},
                  bus_q[0].beat);
            if (cyc >= bus_q[0].last) void'(bus_q.pop_front());
         end
      end else if (bus_q.size() != 0 && cyc > bus_q[0].last) begin
         void'(bus_q.pop_front());
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      rsp_t e;
      if (en && resp_valid) begin
         if (rsp_q.size() == 0) begin
            check("resp_unexpected", resp_valid, 1'b0);
         end else begin
            e = rsp_q.pop_front();
            check("resp{rd,err,data}", {resp_rd, resp_err, resp_data}, {e.rd, e.err, e.data});
            check("resp_cycle", 128'(cyc), 128'(e.at));
         end
      end
   end

   initial begin
      int d;
      clr = 1'b1; req_valid = 1'b1; junk_req();
      mem_ready = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", {req_ready, stall, mem_valid, resp_valid}, 4'b1000);
      check("reset_data", {mem_write, mem_be, mem_addr, mem_wdata, resp_err, resp_rd, resp_data}, '0);
      clr = 1'b0; req_valid = 1'b0;
      en = 1'b1;
      @(negedge clk);

      issue(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 5'd7,  0, 32'h0,        1'b1);
      issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0,      5'd3,  0, 32'h80123456, 1'b1);
      issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0,      5'd4,  0, 32'h80123456, 1'b1);
      issue(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234,   5'd9,  0, 32'h0,        1'b1);
      issue(1'b0, 2'd1, 1'b0, 32'h202, 32'h0,      5'd11, 5, 32'h8001_7F00, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0,      5'd12, NEVER, 32'h0,     1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h304, 32'h0,      5'd13, int'(MAX_WAIT) - 1, 32'hCAFE_F00D, 1'b1);
      issue(1'b0, 2'd2, 1'b0, 32'h102, 32'h0,      5'd14, 0, 32'h1122_3344, 1'b1);
      issue(1'b0, 2'd3, 1'b0, 32'h108, 32'h0,      5'd15, 0, 32'h0,        1'b1);

      // Synchronous clear while the bus is waiting: request abandoned, no response.
      issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd16, NEVER, 32'h0, 1'b0);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk); #1;
      clr = 1'b1; busy_hi = cyc; mv_hi = cyc; rsp_at = -1;
      rsp_q.delete(); bus_q.delete(); plan_q.delete();
      @(negedge clk);
      check("clr_mid_bus", {req_ready, stall, mem_valid, resp_valid}, 4'b1000);
      clr = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 250; i++) begin
         d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 9)) : int'($urandom_range(0, 2));
         issue(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom),
               d, $urandom, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      check("responses_outstanding", 128'(rsp_q.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      fails++;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
